lvds_tx_framer: RTL and testbench

//  Link-layer transmitter for the FPGA-to-FPGA LVDS link. Pops 32-bit words from the TX FIFO and drives
//  the byte-wide serializer input (tx_in), producing the stream the partner's receive deframer expects.

---
 rtl/lvds_tx_framer.sv | 159 +++++++++++++++
 tb/tb_lvds_tx_framer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/lvds_tx_framer.sv
// ---------------------------------------------------------------------------
// lvds_tx_framer
//   Link-layer transmitter for the FPGA-to-FPGA LVDS link. Sends a training
//   pattern until the partner receiver reports alignment, then one sync byte,
//   then 4-byte frames (MSB byte first) popped from a first-word-fall-through
//   TX FIFO. When no word is available, an idle frame of IDLE_BYTE is sent.
//
// Ports
//   tx_inclock     in   serializer parallel clock (only clock)
//   reset          in   synchronous, active-high
//   tx_locked      in   serializer PLL locked
//   tx_align_done  in   partner receiver aligned (level)
//   retrain        in   request re-entry to training (level)
//   enq_tx         in   head word of the TX FIFO
//   RDY_enq_tx     in   TX FIFO non-empty
//   EN_enq_tx      out  pop strobe, high for the B0 cycle of a data frame
//   tx_in          out  byte to the serializer (registered)
//   link_up        out  high in SYNC and B0..B3
//   words_sent     out  completed data frames, wraps
//   state_out      out  current state encoding
// ---------------------------------------------------------------------------
module lvds_tx_framer #(
  parameter logic [7:0] TRAIN_PATTERN = 8'h35,
  parameter logic [7:0] SYNC_PATTERN  = 8'h77,
  parameter logic [7:0] IDLE_BYTE     = 8'h52,
  parameter int         CNT_W         = 16
) (
  input  logic             tx_inclock,
  input  logic             reset,
  input  logic             tx_locked,
  input  logic             tx_align_done,
  input  logic             retrain,
  input  logic [31:0]      enq_tx,
  input  logic             RDY_enq_tx,
  output logic             EN_enq_tx,
  output logic [7:0]       tx_in,
  output logic             link_up,
  output logic [CNT_W-1:0] words_sent,
  output logic [2:0]       state_out
);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_TRAIN     = 3'd1,
    ST_SYNC      = 3'd2,
    ST_B0        = 3'd3,
    ST_B1        = 3'd4,
    ST_B2        = 3'd5,
    ST_B3        = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       tx_in_q, tx_in_d;
  logic             en_q, en_d;
  logic             link_up_q, link_up_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic [31:0]      hold_q, hold_d;
  logic             frame_valid_q, frame_valid_d;

  // NOTE: every variable gets a default first so no path through the case
  // statement leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    tx_in_d       = tx_in_q;
    en_d          = 1'b0;
    hold_d        = hold_q;
    frame_valid_d = frame_valid_q;
    words_d       = words_q;

    if (!tx_locked) begin
      state_d       = ST_WAIT_LOCK;
      tx_in_d       = 8'h00;
      frame_valid_d = 1'b0;
    end else if (retrain && (state_q != ST_WAIT_LOCK)) begin
      // Abandon any frame in flight; a word already popped is lost.
      state_d       = ST_TRAIN;
      tx_in_d       = TRAIN_PATTERN;
      frame_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_WAIT_LOCK: begin
          state_d = ST_TRAIN;
          tx_in_d = TRAIN_PATTERN;
        end
        ST_TRAIN: begin
          if (tx_align_done) begin
            state_d = ST_SYNC;
            tx_in_d = SYNC_PATTERN;
          end
        end
        ST_SYNC, ST_B3: begin
          // The FIFO is sampled only on edges entering B0.
          state_d = ST_B0;
          if (RDY_enq_tx) begin
            hold_d        = enq_tx;
            tx_in_d       = enq_tx[31:24];
            en_d          = 1'b1;
            frame_valid_d = 1'b1;
          end else begin
            hold_d        = {4{IDLE_BYTE}};
            tx_in_d       = IDLE_BYTE;
            frame_valid_d = 1'b0;
          end
        end
        ST_B0: begin
          state_d = ST_B1;
          tx_in_d = hold_q[23:16];
        end
        ST_B1: begin
          state_d = ST_B2;
          tx_in_d = hold_q[15:8];
        end
        ST_B2: begin
          state_d = ST_B3;
          tx_in_d = hold_q[7:0];
          if (frame_valid_q) words_d = words_q + CNT_W'(1);
        end
        default: begin
          state_d = ST_WAIT_LOCK;
          tx_in_d = 8'h00;
        end
      endcase
    end

    link_up_d = (state_d == ST_SYNC) || (state_d == ST_B0) || (state_d == ST_B1) ||
                (state_d == ST_B2)   || (state_d == ST_B3);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge tx_inclock) begin
    if (reset) begin
      state_q       <= ST_WAIT_LOCK;
      tx_in_q       <= 8'h00;
      en_q          <= 1'b0;
      link_up_q     <= 1'b0;
      words_q       <= '0;
      // NOTE: hold and frame_valid are reset too; only a handful of flops,
      // and it keeps the datapath free of X after reset.
      hold_q        <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_in_q       <= tx_in_d;
      en_q          <= en_d;
      link_up_q     <= link_up_d;
      words_q       <= words_d;
      hold_q        <= hold_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign EN_enq_tx  = en_q;
  assign tx_in      = tx_in_q;
  assign link_up    = link_up_q;
  assign words_sent = words_q;
  assign state_out  = state_q;

endmodule

// File: tb/tb_lvds_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_lvds_tx_framer
//   Directed bench for lvds_tx_framer. A second instance with a 2-bit
//   counter shares all inputs so counter wrap is reached in four words.
// ---------------------------------------------------------------------------
module tb_lvds_tx_framer;

  logic        tx_inclock = 1'b0;
  logic        reset;
  logic        tx_locked;
  logic        tx_align_done;
  logic        retrain;
  logic [31:0] enq_tx;
  logic        RDY_enq_tx;

  logic        EN_enq_tx;
  logic [7:0]  tx_in;
  logic        link_up;
  logic [15:0] words_sent;
  logic [2:0]  state_out;

  logic        en_w2;
  logic [7:0]  tx_in_w2;
  logic        link_up_w2;
  logic [1:0]  words_w2;
  logic [2:0]  state_w2;

  int checks = 0;
  int errors = 0;

  logic [31:0] fifo[$];

  always #5 tx_inclock = ~tx_inclock;

  lvds_tx_framer dut (
    .tx_inclock   (tx_inclock),
    .reset        (reset),
    .tx_locked    (tx_locked),
    .tx_align_done(tx_align_done),
    .retrain      (retrain),
    .enq_tx       (enq_tx),
    .RDY_enq_tx   (RDY_enq_tx),
    .EN_enq_tx    (EN_enq_tx),
    .tx_in        (tx_in),
    .link_up      (link_up),
    .words_sent   (words_sent),
    .state_out    (state_out)
  );

  lvds_tx_framer #(.CNT_W(2)) dut_w2 (
    .tx_inclock   (tx_inclock),
    .reset        (reset),
    .tx_locked    (tx_locked),
    .tx_align_done(tx_align_done),
    .retrain      (retrain),
    .enq_tx       (enq_tx),
    .RDY_enq_tx   (RDY_enq_tx),
    .EN_enq_tx    (en_w2),
    .tx_in        (tx_in_w2),
    .link_up      (link_up_w2),
    .words_sent   (words_w2),
    .state_out    (state_w2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Present the FIFO head to the DUT (first-word-fall-through).
  task automatic drive_fifo();
    RDY_enq_tx = (fifo.size() > 0);
    enq_tx     = (fifo.size() > 0) ? fifo[0] : 32'h0;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge tx_inclock);
    #1;
    if (EN_enq_tx && fifo.size() > 0) void'(fifo.pop_front());
    drive_fifo();
  endtask

  task automatic wait_state(input logic [2:0] want, input string tag);
    for (int i = 0; i < 20 && state_out != want; i++) step();
    check(tag, {29'd0, state_out}, {29'd0, want});
  endtask

  // Step through one frame, comparing the four bytes, pop strobe and link_up.
  task automatic expect_frame(input logic [31:0] word, input logic en0, input string tag);
    logic [31:0] w;
    w = word;
    for (int b = 0; b < 4; b++) begin
      step();
      check({tag, "_byte"}, {24'd0, tx_in}, {24'd0, w[31:24]});
      check({tag, "_en"},   {31'd0, EN_enq_tx}, {31'd0, (b == 0) ? en0 : 1'b0});
      check({tag, "_link"}, {31'd0, link_up}, 32'd1);
      w = w << 8;
    end
  endtask

  initial begin
    reset = 1'b1; tx_locked = 1'b0; tx_align_done = 1'b0; retrain = 1'b0;
    drive_fifo();

    // 1: reset, then unlocked idle, then lock -> training.
    for (int i = 0; i < 3; i++) step();
    check("rst_tx",    {24'd0, tx_in}, 32'h00);
    check("rst_en",    {31'd0, EN_enq_tx}, 32'd0);
    check("rst_link",  {31'd0, link_up}, 32'd0);
    check("rst_words", {16'd0, words_sent}, 32'd0);
    check("rst_state", {29'd0, state_out}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("unlock_tx",    {24'd0, tx_in}, 32'h00);
      check("unlock_state", {29'd0, state_out}, 32'd0);
    end
    tx_locked = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("train_tx",    {24'd0, tx_in}, 32'h35);
      check("train_state", {29'd0, state_out}, 32'd1);
      check("train_link",  {31'd0, link_up}, 32'd0);
    end

    // 2: alignment with empty FIFO -> one sync byte, then idle fill.
    tx_align_done = 1'b1;
    step();
    check("sync_tx",    {24'd0, tx_in}, 32'h77);
    check("sync_state", {29'd0, state_out}, 32'd2);
    check("sync_link",  {31'd0, link_up}, 32'd1);
    expect_frame(32'h52525252, 1'b0, "idle0");
    expect_frame(32'h52525252, 1'b0, "idle1");
    check("idle_words", {16'd0, words_sent}, 32'd0);

    // 3: two words back-to-back.
    wait_state(3'd6, "wait_b3_t3");
    fifo.push_back(32'h80A1B2C3);
    fifo.push_back(32'h80000001);
    drive_fifo();
    expect_frame(32'h80A1B2C3, 1'b1, "w0");
    check("w0_words", {16'd0, words_sent}, 32'd1);
    expect_frame(32'h80000001, 1'b1, "w1");
    check("w1_words",    {16'd0, words_sent}, 32'd2);
    check("w1_words_w2", {30'd0, words_w2}, 32'd2);

    // 4: FIFO empties after the pop -> frame completes, then idle.
    fifo.push_back(32'h12345678);
    drive_fifo();
    expect_frame(32'h12345678, 1'b1, "w2");
    check("w2_rdy_low", {31'd0, RDY_enq_tx}, 32'd0);
    check("w2_words",    {16'd0, words_sent}, 32'd3);
    check("w2_words_w2", {30'd0, words_w2}, 32'd3);
    expect_frame(32'h52525252, 1'b0, "idle2");
    check("idle2_words", {16'd0, words_sent}, 32'd3);

    // 5: retrain during B1 abandons the frame.
    fifo.push_back(32'hDEADBEEF);
    drive_fifo();
    step();
    check("rt_b0", {24'd0, tx_in}, 32'hDE);
    step();
    check("rt_b1", {29'd0, state_out}, 32'd4);
    retrain = 1'b1; tx_align_done = 1'b0;
    step();
    check("rt_tx",    {24'd0, tx_in}, 32'h35);
    check("rt_state", {29'd0, state_out}, 32'd1);
    check("rt_link",  {31'd0, link_up}, 32'd0);
    check("rt_en",    {31'd0, EN_enq_tx}, 32'd0);
    retrain = 1'b0;
    step();
    check("rt_hold_tx", {24'd0, tx_in}, 32'h35);
    for (int i = 0; i < 3; i++) step();
    check("rt_words", {16'd0, words_sent}, 32'd3);
    tx_align_done = 1'b1;
    step();
    check("rs_sync", {24'd0, tx_in}, 32'h77);
    // Bit31=0 word is still sent and counted; 2-bit counter wraps 3 -> 0.
    fifo.push_back(32'h00000042);
    drive_fifo();
    expect_frame(32'h00000042, 1'b1, "w3");
    check("w3_words",     {16'd0, words_sent}, 32'd4);
    check("w3_wrap_w2",   {30'd0, words_w2}, 32'd0);

    // 6: lock loss wins over retrain.
    step();
    tx_locked = 1'b0; retrain = 1'b1;
    step();
    check("ll_tx",    {24'd0, tx_in}, 32'h00);
    check("ll_state", {29'd0, state_out}, 32'd0);
    check("ll_link",  {31'd0, link_up}, 32'd0);
    check("ll_en",    {31'd0, EN_enq_tx}, 32'd0);
    check("ll_words", {16'd0, words_sent}, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
